srt_denorm: RTL and testbench
=============================

// Module: srt_denorm
// PURPOSE
//   Iterative right-shift denormalizer: the inverse of leading-zero normalization in the SRT divider.
//   Takes a normalized remainder plus the shift count produced by the divisor's LZD, and shifts it back
//   right by that count, STEP bits per cycle. Sits between the SRT iteration core and result writeback.
//   Also reports a zero flag and a sticky (OR of shifted-out bits).
// PARAMETERS
//   WIDTH  16  data width in bits (power of 2, >= 4)
//   STEP   4   max bits shifted per cycle (power of 2, 1..WIDTH)
//   SHW    $clog2(WIDTH)  localparam: shift-amount width
// PORTS
//   clk        in   1      clock; all state updates on rising edge
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      request valid
//   in_ready   out  1      block can accept request (IDLE only)
//   in_data    in   WIDTH  normalized remainder
//   in_shamt   in   SHW    right-shift amount, 0..WIDTH-1
//   out_valid  out  1      result valid (DONE only)
//   out_ready  in   1      consumer accepts result
//   out_data   out  WIDTH  in_data >> in_shamt
//   out_zero   out  1      out_data == 0
//   out_sticky out  1      OR of all bits shifted out
//   busy       out  1      state != IDLE
// BEHAVIOUR
//   - Reset (rst_n=0 at clk edge): state=IDLE, data/cnt/sticky regs=0; in_ready=1 from next cycle,
//     out_valid=0, out_data=0, out_zero=1, out_sticky=0, busy=0. Applies mid-operation: in-flight op discarded.
//   - FSM states IDLE, SHIFT, DONE:
//     IDLE : in_ready=1. in_valid&in_ready -> load data=in_data, cnt=in_shamt, sticky=0; go SHIFT.
//     SHIFT: if cnt>=STEP: data>>=STEP, sticky|=|data[STEP-1:0], cnt-=STEP, stay.
//            else: data>>=cnt, sticky|=OR of low cnt bits, cnt=0, go DONE.
//     DONE : out_valid=1; out_data/out_zero/out_sticky stable until out_valid&out_ready, then go IDLE.
//   - Cycles in SHIFT = floor(in_shamt/STEP)+1 (shamt=0 -> one SHIFT cycle). Accept-to-out_valid latency
//     = that count; out_valid rises the cycle after the final SHIFT cycle.
//   - No request accepted in SHIFT/DONE (in_ready=0); in_data/in_shamt ignored there.
//   - DONE->IDLE on handshake; next request may be accepted the following cycle (no same-cycle pass-through).
//   - out_ready held low: DONE held indefinitely, outputs unchanged.
//   - Shift is logical (zero fill) unless the optional feature is enabled.
//   - out_zero, out_sticky are combinational from the registered data/sticky; valid only with out_valid.
//   - Registers are updated only by the FSM transitions above; no X on outputs after reset.
// CONFIGURATION
//   SRT_DENORM_SIGNED_EN defined: arithmetic shift; vacated MSBs fill with in_data[WIDTH-1] captured at
//     load (negative SRT partial remainder). Sticky semantics unchanged.
//   SRT_DENORM_SIGNED_EN undefined: logical shift, zero fill; no sign logic synthesized.
// TESTING (WIDTH=16, STEP=4)
//   1. in_data=16'hF000, in_shamt=12 -> 4 SHIFT cycles; out_data=16'h000F, out_sticky=0, out_zero=0.
//   2. in_data=16'h8001, in_shamt=0 -> out_valid after 1 SHIFT cycle; out_data=16'h8001, sticky=0.
//   3. in_data=16'h00A5, in_shamt=9 -> out_data=16'h0000, out_zero=1, out_sticky=1.
//   4. out_ready=0 for 10 cycles in DONE -> out_valid stays 1, outputs stable, in_ready=0; then handshake ->
//      in_ready=1 next cycle; back-to-back second request completes correctly.
//   5. rst_n=0 during SHIFT (in_shamt=15) -> next cycle IDLE, out_valid=0, busy=0, in_ready=1.
//   6. SRT_DENORM_SIGNED_EN: in_data=16'h8000, in_shamt=4 -> out_data=16'hF800; undefined -> 16'h0800.

Source files
------------

// File: rtl/srt_denorm.sv
// Iterative right-shift denormalizer for the SRT divider: undoes LZD normalization STEP bits per cycle,
// reporting zero and sticky. Define SRT_DENORM_SIGNED_EN for arithmetic (sign-fill) shifting.
module srt_denorm #(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned STEP  = 4,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_sticky,
    output logic             busy
);

    // One extra bit so STEP == WIDTH is representable alongside the count.
    localparam int unsigned    AW     = SHW + 1;
    localparam logic [AW-1:0]  STEP_A = AW'(STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             sticky_q, sticky_d;
    logic [AW-1:0]    amt_c;
    logic [WIDTH-1:0] lost_mask_c;
    logic [WIDTH-1:0] shifted_c;

`ifdef SRT_DENORM_SIGNED_EN
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] fill_mask_c;
`endif

    // Bits moved this cycle: a full STEP, or the remaining count on the final pass.
    assign amt_c       = (AW'(cnt_q) >= STEP_A) ? STEP_A : AW'(cnt_q);
    assign lost_mask_c = ~({WIDTH{1'b1}} << amt_c);

`ifdef SRT_DENORM_SIGNED_EN
    assign fill_mask_c = ~({WIDTH{1'b1}} >> amt_c);
    assign shifted_c   = (data_q >> amt_c) | (sign_q ? fill_mask_c : '0);
`else
    assign shifted_c   = data_q >> amt_c;
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            data_q   <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
`ifdef SRT_DENORM_SIGNED_EN
            sign_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
`ifdef SRT_DENORM_SIGNED_EN
            sign_q   <= sign_d;
`endif
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
`ifdef SRT_DENORM_SIGNED_EN
        sign_d   = sign_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d   = in_data;
                    cnt_d    = in_shamt;
                    sticky_d = 1'b0;
`ifdef SRT_DENORM_SIGNED_EN
                    sign_d   = in_data[WIDTH-1];
`endif
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                data_d   = shifted_c;
                sticky_d = sticky_q | (|(data_q & lost_mask_c));
                if (AW'(cnt_q) >= STEP_A) begin
                    cnt_d = cnt_q - SHW'(STEP);
                end else begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign out_data   = data_q;
    assign out_zero   = ~|data_q;
    assign out_sticky = sticky_q;

endmodule

// File: tb/tb_srt_denorm.sv
// Bench for srt_denorm (WIDTH=16, STEP=4): directed table, hand-written stall/reset sequences,
// and random operations against an arithmetic reference model.
module tb_srt_denorm;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_shamt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_zero;
    logic        out_sticky;
    logic        busy;

    int n_checks = 0;
    int n_fails  = 0;

    srt_denorm #(.WIDTH(16), .STEP(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_shamt   (in_shamt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_zero   (out_zero),
        .out_sticky (out_sticky),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        int          sh;
        logic [15:0] ed;
        logic        ez;
        logic        es;
        int          el;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: value divided down by 2**sh (floor, so negative values fill with ones when signed).
    function automatic logic [15:0] ref_data(input logic [15:0] d, input int sh);
        int v;
        v = int'(d);
`ifdef SRT_DENORM_SIGNED_EN
        if (d[15]) v = v - 65536;
        v = v >>> sh;
`else
        v = v / (1 << sh);
`endif
        return 16'(v);
    endfunction

    function automatic logic ref_sticky(input logic [15:0] d, input int sh);
        return (int'(d) % (1 << sh)) != 0;
    endfunction

    // Issue one request, wait for the result, hold it for 'hold' cycles, then hand it off.
    task automatic run_op(input string name, input logic [15:0] d, input int sh, input int hold,
                          input logic [15:0] ed, input logic ez, input logic es, input int el);
        int lat;
        check({name, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = 4'(sh);
        tick();
        // Garbage on the request side must be ignored until the block is idle again.
        in_valid = 1'b1;
        in_data  = 16'($urandom);
        in_shamt = 4'($urandom);
        lat = 0;
        while (!out_valid && lat < 64) begin
            tick();
            lat++;
        end
        check({name, ".latency"}, 32'(lat), 32'(el));
        check({name, ".data"}, 32'(out_data), 32'(ed));
        check({name, ".zero"}, 32'(out_zero), 32'(ez));
        check({name, ".sticky"}, 32'(out_sticky), 32'(es));
        for (int i = 0; i < hold; i++) begin
            tick();
            check({name, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({name, ".hold_data"}, {15'd0, out_sticky, out_data}, {15'd0, es, ed});
            check({name, ".hold_ready"}, {30'd0, in_ready, busy}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, ".post_hs"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        out_ready = 1'b0;

`ifdef SRT_DENORM_SIGNED_EN
        vecs[0] = '{16'hF000, 12, 16'hFFFF, 1'b0, 1'b0, 4};
        vecs[3] = '{16'h8000,  4, 16'hF800, 1'b0, 1'b0, 2};
        vecs[4] = '{16'hFFFF, 15, 16'hFFFF, 1'b0, 1'b1, 4};
        vecs[7] = '{16'hC000,  8, 16'hFFC0, 1'b0, 1'b0, 3};
`else
        vecs[0] = '{16'hF000, 12, 16'h000F, 1'b0, 1'b0, 4};
        vecs[3] = '{16'h8000,  4, 16'h0800, 1'b0, 1'b0, 2};
        vecs[4] = '{16'hFFFF, 15, 16'h0001, 1'b0, 1'b1, 4};
        vecs[7] = '{16'hC000,  8, 16'h00C0, 1'b0, 1'b0, 3};
`endif
        vecs[1] = '{16'h8001,  0, 16'h8001, 1'b0, 1'b0, 1};
        vecs[2] = '{16'h00A5,  9, 16'h0000, 1'b1, 1'b1, 3};
        vecs[5] = '{16'h0001,  1, 16'h0000, 1'b1, 1'b1, 1};
        vecs[6] = '{16'h1234,  3, 16'h0246, 1'b0, 1'b1, 1};

        tick();
        tick();
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.out", {14'd0, out_zero, out_sticky, out_data}, {14'd0, 1'b1, 1'b0, 16'h0000});
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].d, vecs[i].sh, 0,
                   vecs[i].ed, vecs[i].ez, vecs[i].es, vecs[i].el);
        end

        // Long stall in DONE, then an immediate back-to-back request.
        run_op("stall", 16'hF000, 12, 10, ref_data(16'hF000, 12), ref_data(16'hF000, 12) == 16'h0,
               1'b0, 4);
        run_op("b2b", 16'h00A5, 9, 0, 16'h0000, 1'b1, 1'b1, 3);

        // Reset while shifting discards the operation.
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        in_shamt = 4'd15;
        tick();
        in_valid = 1'b0;
        tick();
        check("midrst.busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst.state", {29'd0, out_valid, busy, in_ready}, 32'd1);
        check("midrst.out", {14'd0, out_zero, out_sticky, out_data}, {14'd0, 1'b1, 1'b0, 16'h0000});
        tick();
        check("midrst.idle_hold", 32'(in_ready), 32'd1);
        run_op("after_rst", 16'h8000, 4, 1, ref_data(16'h8000, 4), 1'b0, 1'b0, 2);

        for (int k = 0; k < 40; k++) begin
            logic [15:0] d;
            logic [15:0] ed;
            int          sh;
            d  = 16'($urandom);
            sh = int'($urandom_range(15, 0));
            if (k % 8 == 0) d = 16'h0000;
            ed = ref_data(d, sh);
            run_op($sformatf("rnd%0d", k), d, sh, int'($urandom_range(3, 0)),
                   ed, ed == 16'h0, ref_sticky(d, sh), sh / 4 + 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
